line_delay_ctrl: RTL and testbench

// - Controller directly upstream of an inner_sram/LakeTop line buffer in the stencil pipeline.
// - Accepts a raster pixel stream and writes each pixel into the SRAM at a circular column address.
// - From row 1 onward it reads back the pixel one row above (same column) and emits an aligned
//   (current, previous-row) pair, the 2-row stencil column consumed by the downstream compute stage.

---
 rtl/line_delay_ctrl_if.sv | 33 +++
 rtl/line_delay_ctrl.sv | 113 +++++++++++
 tb/tb_line_delay_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_delay_ctrl_if.sv
// Pixel stream, SRAM port and stencil output bundle of the line-delay controller.
// slave is the controller's view; master is the view of whatever surrounds it.
interface line_delay_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_waddr;
  logic [DATA_W-1:0] sram_wdata;
  logic              sram_ren;
  logic [ADDR_W-1:0] sram_raddr;
  logic [DATA_W-1:0] sram_rdata;
  logic              out_valid;
  logic [DATA_W-1:0] out_cur;
  logic [DATA_W-1:0] out_prev;
  logic              frame_done;

  modport slave (
    input  flush, in_valid, in_data, sram_rdata,
    output in_ready, sram_wen, sram_waddr, sram_wdata, sram_ren, sram_raddr,
           out_valid, out_cur, out_prev, frame_done
  );

  modport master (
    output flush, in_valid, in_data, sram_rdata,
    input  in_ready, sram_wen, sram_waddr, sram_wdata, sram_ren, sram_raddr,
           out_valid, out_cur, out_prev, frame_done
  );
endinterface

// File: rtl/line_delay_ctrl.sv
// Line-buffer controller: writes each raster pixel at its column address and, from row 1 on,
// reads the word one row above to emit (current, previous-row) stencil column pairs.
module line_delay_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64
) (
  input logic               clk,
  input logic               rst,
  line_delay_ctrl_if.slave  bus
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  typedef enum logic {FILL = 1'b0, STEADY = 1'b1} state_t;

  state_t            state, state_n;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              xfer, col_last, row_last, steady;

  logic              wen_p0;
  logic [ADDR_W-1:0] waddr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic              vld_p0;
  logic [DATA_W-1:0] cur_p0;
  logic [DATA_W-1:0] prev_hold_p0;
  logic              done_p0;

  assign bus.in_ready = !rst && !bus.flush;
  assign xfer         = bus.in_valid && bus.in_ready;
  assign col_last     = (col == COL_W'(IMG_W - 1));
  assign row_last     = (row == ROW_W'(IMG_H - 1));
  assign steady       = (state == STEADY);

  always_comb begin
    state_n = state;
    if (xfer && col_last) begin
      if (state == FILL)
        state_n = STEADY;
      else if (row_last)
        state_n = FILL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      col   <= '0;
      row   <= '0;
    end else if (bus.flush) begin
      state <= FILL;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_n;
      if (xfer) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Stage 0: read of the row-above word issues with the transfer itself.
  assign bus.sram_ren   = xfer && steady;
  assign bus.sram_raddr = ADDR_W'(col);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_p0       <= 1'b0;
      waddr_p0     <= '0;
      wdata_p0     <= '0;
      vld_p0       <= 1'b0;
      cur_p0       <= '0;
      prev_hold_p0 <= '0;
      done_p0      <= 1'b0;
    end else if (bus.flush) begin
      wen_p0       <= 1'b0;
      waddr_p0     <= '0;
      wdata_p0     <= '0;
      vld_p0       <= 1'b0;
      cur_p0       <= '0;
      prev_hold_p0 <= '0;
      done_p0      <= 1'b0;
    end else begin
      wen_p0  <= xfer;
      vld_p0  <= xfer && steady;
      done_p0 <= xfer && steady && col_last && row_last;
      if (xfer) begin
        waddr_p0 <= ADDR_W'(col);
        wdata_p0 <= bus.in_data;
      end
      if (xfer && steady)
        cur_p0 <= bus.in_data;
      if (vld_p0)
        prev_hold_p0 <= bus.sram_rdata;
    end
  end

  // Stage 1: write lands one cycle after its read, so the old word is always read first.
  assign bus.sram_wen   = wen_p0;
  assign bus.sram_waddr = waddr_p0;
  assign bus.sram_wdata = wdata_p0;
  assign bus.out_valid  = vld_p0;
  assign bus.out_cur    = cur_p0;
  assign bus.out_prev   = vld_p0 ? bus.sram_rdata : prev_hold_p0;
  assign bus.frame_done = done_p0;
endmodule

// File: tb/tb_line_delay_ctrl.sv
// Bench for line_delay_ctrl: a 4x3 instance (ramp table, async reset, flush, random gaps)
// and a 2x2 instance (minimum-size frame), each backed by a small SRAM model.
module tb_line_delay_ctrl;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int WA = 4;
  localparam int HA = 3;
  localparam int WB = 2;
  localparam int HB = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  line_delay_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) ifa ();
  line_delay_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) ifb ();

  line_delay_ctrl #(.DATA_W(DW), .ADDR_W(AW), .IMG_W(WA), .IMG_H(HA)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  line_delay_ctrl #(.DATA_W(DW), .ADDR_W(AW), .IMG_W(WB), .IMG_H(HB)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  logic [DW-1:0] mem_a [64];
  logic [DW-1:0] mem_b [64];

  always @(posedge clk) begin
    if (ifa.sram_ren) ifa.sram_rdata <= mem_a[ifa.sram_raddr[5:0]];
    if (ifa.sram_wen) mem_a[ifa.sram_waddr[5:0]] <= ifa.sram_wdata;
    if (ifb.sram_ren) ifb.sram_rdata <= mem_b[ifb.sram_raddr[5:0]];
    if (ifb.sram_wen) mem_b[ifb.sram_waddr[5:0]] <= ifb.sram_wdata;
  end

  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic        wen;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic        ren;
    logic [15:0] raddr;
    logic        ov;
    logic [15:0] cur;
    logic [15:0] prev;
    logic        done;
  } vec_t;

  typedef struct packed {
    logic [15:0] cur;
    logic [15:0] prev;
    logic        done;
  } pair_t;

  vec_t        tbl [$];
  vec_t        tv;
  pair_t       exp_q [$];
  pair_t       ep;
  logic [15:0] fr [WA*HA];
  logic [15:0] pix;
  int          k, sent, dones, drain;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  function automatic vec_t mk(input int v, input int d, input int wen, input int waddr,
                              input int wdata, input int ren, input int raddr, input int ov,
                              input int cur, input int prev, input int done);
    vec_t r;
    r.v     = v[0];
    r.d     = d[15:0];
    r.wen   = wen[0];
    r.waddr = waddr[15:0];
    r.wdata = wdata[15:0];
    r.ren   = ren[0];
    r.raddr = raddr[15:0];
    r.ov    = ov[0];
    r.cur   = cur[15:0];
    r.prev  = prev[15:0];
    r.done  = done[0];
    return r;
  endfunction

  task automatic chk_a_zero(input string tag);
    chk({tag, "_in_ready"},   32'(ifa.in_ready),   32'd0);
    chk({tag, "_wen"},        32'(ifa.sram_wen),   32'd0);
    chk({tag, "_waddr"},      32'(ifa.sram_waddr), 32'd0);
    chk({tag, "_wdata"},      32'(ifa.sram_wdata), 32'd0);
    chk({tag, "_ren"},        32'(ifa.sram_ren),   32'd0);
    chk({tag, "_raddr"},      32'(ifa.sram_raddr), 32'd0);
    chk({tag, "_out_valid"},  32'(ifa.out_valid),  32'd0);
    chk({tag, "_out_cur"},    32'(ifa.out_cur),    32'd0);
    chk({tag, "_out_prev"},   32'(ifa.out_prev),   32'd0);
    chk({tag, "_frame_done"}, 32'(ifa.frame_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b0;
    ifa.flush = 1'b0; ifa.in_valid = 1'b0; ifa.in_data = '0;
    ifb.flush = 1'b0; ifb.in_valid = 1'b0; ifb.in_data = '0;
    #1 rst = 1'b1;
    #1 chk_a_zero("reset");
    chk("reset_b_in_ready", 32'(ifb.in_ready), 32'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_in_ready", 32'(ifa.in_ready), 32'd1);

    // 4x3 ramp, continuous, then one idle cycle
    tbl.push_back(mk(1,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
    tbl.push_back(mk(1,  1, 1, 0,  0, 0, 1, 0,  0, 0, 0));
    tbl.push_back(mk(1,  2, 1, 1,  1, 0, 2, 0,  0, 0, 0));
    tbl.push_back(mk(1,  3, 1, 2,  2, 0, 3, 0,  0, 0, 0));
    tbl.push_back(mk(1,  4, 1, 3,  3, 1, 0, 0,  0, 0, 0));
    tbl.push_back(mk(1,  5, 1, 0,  4, 1, 1, 1,  4, 0, 0));
    tbl.push_back(mk(1,  6, 1, 1,  5, 1, 2, 1,  5, 1, 0));
    tbl.push_back(mk(1,  7, 1, 2,  6, 1, 3, 1,  6, 2, 0));
    tbl.push_back(mk(1,  8, 1, 3,  7, 1, 0, 1,  7, 3, 0));
    tbl.push_back(mk(1,  9, 1, 0,  8, 1, 1, 1,  8, 4, 0));
    tbl.push_back(mk(1, 10, 1, 1,  9, 1, 2, 1,  9, 5, 0));
    tbl.push_back(mk(1, 11, 1, 2, 10, 1, 3, 1, 10, 6, 0));
    tbl.push_back(mk(1, 12, 1, 3, 11, 0, 0, 1, 11, 7, 1));
    tbl.push_back(mk(0,  0, 1, 0, 12, 0, 0, 0, 11, 7, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      tv = tbl[i];
      @(posedge clk); #1;
      ifa.in_valid = tv.v;
      ifa.in_data  = tv.d;
      @(negedge clk);
      chk($sformatf("ramp%0d_in_ready", i), 32'(ifa.in_ready), 32'd1);
      chk($sformatf("ramp%0d_wen", i), 32'(ifa.sram_wen), 32'(tv.wen));
      if (tv.wen) begin
        chk($sformatf("ramp%0d_waddr", i), 32'(ifa.sram_waddr), 32'(tv.waddr));
        chk($sformatf("ramp%0d_wdata", i), 32'(ifa.sram_wdata), 32'(tv.wdata));
      end
      chk($sformatf("ramp%0d_ren", i), 32'(ifa.sram_ren), 32'(tv.ren));
      if (tv.ren) chk($sformatf("ramp%0d_raddr", i), 32'(ifa.sram_raddr), 32'(tv.raddr));
      chk($sformatf("ramp%0d_out_valid", i), 32'(ifa.out_valid), 32'(tv.ov));
      chk($sformatf("ramp%0d_out_cur", i), 32'(ifa.out_cur), 32'(tv.cur));
      chk($sformatf("ramp%0d_out_prev", i), 32'(ifa.out_prev), 32'(tv.prev));
      chk($sformatf("ramp%0d_frame_done", i), 32'(ifa.frame_done), 32'(tv.done));
    end

    // async reset mid-cycle while a pixel is being offered
    @(posedge clk); #1;
    ifa.in_valid = 1'b1; ifa.in_data = 16'h55;
    #2 rst = 1'b1;
    #1 chk_a_zero("async_rst");
    ifa.in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("async_rst_release_in_ready", 32'(ifa.in_ready), 32'd1);
    chk("async_rst_release_out_valid", 32'(ifa.out_valid), 32'd0);

    // flush after pixel 6 of the frame
    for (int i = 0; i < 7; i++) begin
      ifa.in_valid = 1'b1; ifa.in_data = 16'(16'h100 + i);
      @(posedge clk); #1;
    end
    ifa.flush = 1'b1; ifa.in_data = 16'h1FF;
    @(negedge clk);
    chk("flush_in_ready", 32'(ifa.in_ready), 32'd0);
    chk("flush_pix6_out_valid", 32'(ifa.out_valid), 32'd1);
    chk("flush_pix6_cur", 32'(ifa.out_cur), 32'h106);
    chk("flush_pix6_prev", 32'(ifa.out_prev), 32'h102);
    chk("flush_pix6_waddr", 32'(ifa.sram_waddr), 32'd2);
    @(posedge clk); #1;
    ifa.flush = 1'b0; ifa.in_data = 16'h150;
    @(negedge clk);
    chk("flush_next_wen", 32'(ifa.sram_wen), 32'd0);
    chk("flush_next_ren", 32'(ifa.sram_ren), 32'd0);
    chk("flush_next_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("flush_next_cur_cleared", 32'(ifa.out_cur), 32'd0);
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_row0_wen", 32'(ifa.sram_wen), 32'd1);
    chk("flush_row0_waddr", 32'(ifa.sram_waddr), 32'd0);
    chk("flush_row0_wdata", 32'(ifa.sram_wdata), 32'h150);
    chk("flush_row0_out_valid", 32'(ifa.out_valid), 32'd0);
    @(posedge clk); #1;
    ifa.flush = 1'b1;
    @(posedge clk); #1;
    ifa.flush = 1'b0;

    // two frames with random valid gaps against a frame-array reference model
    k = 0; sent = 0; dones = 0; drain = 0;
    for (int cyc = 0; cyc < 400 && drain < 3; cyc++) begin
      if (sent < 2*WA*HA && $urandom_range(0, 1) == 1) begin
        pix = 16'($urandom);
        ifa.in_valid = 1'b1;
        ifa.in_data  = pix;
        fr[k] = pix;
        if (k >= WA) begin
          ep.cur  = pix;
          ep.prev = fr[k-WA];
          ep.done = (k == WA*HA-1);
          exp_q.push_back(ep);
        end
        k = (k + 1) % (WA*HA);
        sent++;
      end else begin
        ifa.in_valid = 1'b0;
      end
      if (sent == 2*WA*HA) drain++;
      @(negedge clk);
      if (ifa.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_pair", 32'd1, 32'd0);
        end else begin
          ep = exp_q.pop_front();
          chk("rand_cur", 32'(ifa.out_cur), 32'(ep.cur));
          chk("rand_prev", 32'(ifa.out_prev), 32'(ep.prev));
          chk("rand_frame_done", 32'(ifa.frame_done), 32'(ep.done));
        end
      end else begin
        chk("rand_done_without_valid", 32'(ifa.frame_done), 32'd0);
      end
      if (ifa.frame_done) dones++;
      if (ifa.sram_ren && ifa.sram_wen)
        chk("rand_addr_clash", 32'(ifa.sram_raddr == ifa.sram_waddr), 32'd0);
      @(posedge clk); #1;
    end
    ifa.in_valid = 1'b0;
    chk("rand_pixels_sent", 32'(sent), 32'(2*WA*HA));
    chk("rand_pairs_outstanding", 32'(exp_q.size()), 32'd0);
    chk("rand_frame_done_count", 32'(dones), 32'd2);

    // 2x2 minimum frame
    ifb.in_valid = 1'b1; ifb.in_data = 16'hA;
    @(negedge clk);
    chk("b0_ren", 32'(ifb.sram_ren), 32'd0);
    chk("b0_out_valid", 32'(ifb.out_valid), 32'd0);
    @(posedge clk); #1;
    ifb.in_data = 16'hB;
    @(negedge clk);
    chk("b1_wen", 32'(ifb.sram_wen), 32'd1);
    chk("b1_wdata", 32'(ifb.sram_wdata), 32'hA);
    chk("b1_ren", 32'(ifb.sram_ren), 32'd0);
    @(posedge clk); #1;
    ifb.in_data = 16'hC;
    @(negedge clk);
    chk("b2_ren", 32'(ifb.sram_ren), 32'd1);
    chk("b2_raddr", 32'(ifb.sram_raddr), 32'd0);
    chk("b2_out_valid", 32'(ifb.out_valid), 32'd0);
    @(posedge clk); #1;
    ifb.in_data = 16'hD;
    @(negedge clk);
    chk("b3_raddr", 32'(ifb.sram_raddr), 32'd1);
    chk("b3_out_valid", 32'(ifb.out_valid), 32'd1);
    chk("b3_cur", 32'(ifb.out_cur), 32'hC);
    chk("b3_prev", 32'(ifb.out_prev), 32'hA);
    chk("b3_frame_done", 32'(ifb.frame_done), 32'd0);
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
    @(negedge clk);
    chk("b4_out_valid", 32'(ifb.out_valid), 32'd1);
    chk("b4_cur", 32'(ifb.out_cur), 32'hD);
    chk("b4_prev", 32'(ifb.out_prev), 32'hB);
    chk("b4_frame_done", 32'(ifb.frame_done), 32'd1);
    chk("b4_waddr", 32'(ifb.sram_waddr), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b5_out_valid", 32'(ifb.out_valid), 32'd0);
    chk("b5_frame_done", 32'(ifb.frame_done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
